// File: rtl/add_share_arbiter_if.sv
// Bundle of the requester, shared-adder and response signals of add_share_arbiter.
// slave: the arbiter's view. master: the environment's view (requesters, adder, consumers).
interface add_share_arbiter_if #(
  parameter int N = 32
);
  logic         req0_valid;
  logic         req1_valid;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req0_cin;
  logic         req1_cin;
  logic         req0_ready;
  logic         req1_ready;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_ci;
  logic [N-1:0] add_so;
  logic         add_co;
  logic         rsp0_valid;
  logic         rsp1_valid;
  logic [N-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp0_ready;
  logic         rsp1_ready;
  logic         busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin,
    input  add_so, add_co, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, add_a, add_b, add_ci,
    output rsp0_valid, rsp1_valid, rsp_sum, rsp_cout, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin,
    output add_so, add_co, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, add_a, add_b, add_ci,
    input  rsp0_valid, rsp1_valid, rsp_sum, rsp_cout, busy
  );
endinterface

// File: rtl/add_share_arbiter.sv
// Two-requester round-robin arbiter time-sharing one external ripple-carry adder.
// The block never adds: it registers the winner's operands onto the adder inputs,
// waits SETTLE cycles, then captures the adder's sum/carry for the owning requester.
module add_share_arbiter #(
  parameter int N      = 32,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  add_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Settle counter is loaded with SETTLE-1 so ADD lasts exactly SETTLE cycles.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic         last_q;
  logic         owner_q;
  logic         en_q;
  logic [N-1:0] add_a_q;
  logic [N-1:0] add_b_q;
  logic         add_ci_q;
  logic [N-1:0] sum_q;
  logic         cout_q;

  logic         gnt_s;
  logic         take_s;
  logic         rsp_hs_s;

  // Round-robin pick: a tie goes to the requester that did not win last time.
  always_comb begin
    gnt_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_s = ~last_q;
    end else if (bus.req1_valid) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  // en_q keeps ready low for the first cycle after reset release.
  assign take_s   = en_q && (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign rsp_hs_s = (state_q == ST_RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

  // Transaction FSM: accept, settle the adder, hold the result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      en_q     <= 1'b0;
      add_a_q  <= '0;
      add_b_q  <= '0;
      add_ci_q <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      en_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (take_s) begin
            add_a_q  <= gnt_s ? bus.req1_a   : bus.req0_a;
            add_b_q  <= gnt_s ? bus.req1_b   : bus.req0_b;
            add_ci_q <= gnt_s ? bus.req1_cin : bus.req0_cin;
            owner_q  <= gnt_s;
            last_q   <= gnt_s;
            cnt_q    <= CNT_LOAD;
            state_q  <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (cnt_q == 4'd0) begin
            sum_q   <= bus.add_so;
            cout_q  <= bus.add_co;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_hs_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = take_s && !gnt_s;
  assign bus.req1_ready = take_s && gnt_s;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.add_ci     = add_ci_q;
  assign bus.rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == ST_RESP) && owner_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
